// File: rtl/wide_to_narrow_gearbox_pkg.sv
// -----------------------------------------------------------------------------
// wide_to_narrow_gearbox_pkg
//   Shared definitions for the wide-to-narrow gearbox: default geometry,
//   width helpers and the geometry legality check used at elaboration.
// -----------------------------------------------------------------------------
package wide_to_narrow_gearbox_pkg;

  localparam int DEF_WORD_LEN  = 66;
  localparam int DEF_IN_WORDS  = 20;
  localparam int DEF_OUT_WORDS = 5;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of a counter able to hold 0..words inclusive.
  function automatic int calc_cw(input int words);
    return clog2(words + 1);
  endfunction

  // Number of narrow chunks in a full wide beat.
  function automatic int calc_nch(input int in_words, input int out_words);
    return in_words / out_words;
  endfunction

  // A wide beat must split into a whole number of narrow beats.
  function automatic bit ratio_ok(input int in_words, input int out_words);
    return (out_words > 0) && (in_words >= out_words) && ((in_words % out_words) == 0);
  endfunction

endpackage

// File: rtl/wide_to_narrow_gearbox_if.sv
// -----------------------------------------------------------------------------
// wide_to_narrow_gearbox_if
//   Bundles both handshakes of the gearbox.
//   master : the environment (drives din side, consumes dout side)
//   slave  : the gearbox
//   din/din_words/din_valid/din_ready     wide input beat and handshake
//   dout/dout_words/dout_last/dout_valid/dout_ready  narrow output beat
// -----------------------------------------------------------------------------
interface wide_to_narrow_gearbox_if
  import wide_to_narrow_gearbox_pkg::*;
#(
  parameter int WORD_LEN  = DEF_WORD_LEN,
  parameter int IN_WORDS  = DEF_IN_WORDS,
  parameter int OUT_WORDS = DEF_OUT_WORDS
);

  localparam int CW  = calc_cw(IN_WORDS);
  localparam int OCW = calc_cw(OUT_WORDS);

  logic [IN_WORDS*WORD_LEN-1:0]  din;
  logic [CW-1:0]                 din_words;
  logic                          din_valid;
  logic                          din_ready;

  logic [OUT_WORDS*WORD_LEN-1:0] dout;
  logic [OCW-1:0]                dout_words;
  logic                          dout_last;
  logic                          dout_valid;
  logic                          dout_ready;

  modport master (
    output din, din_words, din_valid, dout_ready,
    input  din_ready, dout, dout_words, dout_last, dout_valid
  );

  modport slave (
    input  din, din_words, din_valid, dout_ready,
    output din_ready, dout, dout_words, dout_last, dout_valid
  );

endinterface

// File: rtl/wide_to_narrow_gearbox_chunk_ctrl.sv
// -----------------------------------------------------------------------------
// wide_to_narrow_gearbox_chunk_ctrl
//   Chunk bookkeeping for the gearbox: remaining-chunk counter, tail word
//   count, both handshakes and the per-beat flags.
//   clk, srst          clock, synchronous active-high reset
//   din_valid/ready    input handshake
//   din_words          requested word count (0 or > IN_WORDS means full)
//   dout_ready         output consumer ready
//   dout_valid/last    output beat present / final chunk of the wide beat
//   dout_words         valid words in the current narrow beat
//   w_eff              clamped word count, used by the datapath for masking
//   load               wide beat accepted this cycle
//   advance            chunk leaves without a new load (datapath shifts)
// -----------------------------------------------------------------------------
module wide_to_narrow_gearbox_chunk_ctrl
  import wide_to_narrow_gearbox_pkg::*;
#(
  parameter int IN_WORDS  = DEF_IN_WORDS,
  parameter int OUT_WORDS = DEF_OUT_WORDS
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic                           din_valid,
  input  logic [calc_cw(IN_WORDS)-1:0]   din_words,
  input  logic                           dout_ready,
  output logic                           din_ready,
  output logic                           dout_valid,
  output logic                           dout_last,
  output logic [calc_cw(OUT_WORDS)-1:0]  dout_words,
  output logic [calc_cw(IN_WORDS)-1:0]   w_eff,
  output logic                           load,
  output logic                           advance
);

  localparam int NCH = calc_nch(IN_WORDS, OUT_WORDS);
  localparam int CW  = calc_cw(IN_WORDS);
  localparam int OCW = calc_cw(OUT_WORDS);
  localparam int RW  = calc_cw(NCH);

  logic [RW-1:0]  remaining_q;
  logic [OCW-1:0] tail_q;
  logic           xfer;

  int w_int;
  int n_int;
  int tail_int;

  // Clamp the requested count, then derive chunk count and final-chunk size.
  // NOTE: every always_comb output is given a value before any condition so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_int = int'(din_words);
    if ((w_int == 0) || (w_int > IN_WORDS)) w_int = IN_WORDS;
    n_int    = (w_int + OUT_WORDS - 1) / OUT_WORDS;
    tail_int = w_int - (n_int - 1) * OUT_WORDS;
  end

  assign w_eff = CW'(w_int);

  // The last chunk may leave in the same cycle a new beat loads: no bubble.
  assign dout_valid = (remaining_q != '0);
  assign dout_last  = (remaining_q == RW'(1));
  assign din_ready  = (remaining_q == '0) || (dout_last && dout_ready);
  assign load       = din_valid && din_ready;
  assign xfer       = dout_valid && dout_ready;
  assign advance    = xfer && !load;

  assign dout_words = !dout_valid ? '0 :
                      dout_last   ? tail_q : OCW'(OUT_WORDS);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (srst) begin
      remaining_q <= '0;
      tail_q      <= '0;
    end else if (load) begin
      remaining_q <= RW'(n_int);
      tail_q      <= OCW'(tail_int);
    end else if (xfer) begin
      remaining_q <= remaining_q - RW'(1);
    end
  end

endmodule

// File: rtl/wide_to_narrow_gearbox.sv
// -----------------------------------------------------------------------------
// wide_to_narrow_gearbox
//   Splits one wide beat of IN_WORDS words into successive narrow beats of
//   OUT_WORDS words. Partial beats (din_words) are zero-masked; the final
//   chunk carries the tail word count and dout_last. MSB_FIRST selects
//   whether the top or the bottom chunk of the wide beat leaves first.
//   clk, srst   clock, synchronous active-high reset
//   bus         wide_to_narrow_gearbox_if.slave (both handshakes)
// -----------------------------------------------------------------------------
module wide_to_narrow_gearbox
  import wide_to_narrow_gearbox_pkg::*;
#(
  parameter int WORD_LEN  = DEF_WORD_LEN,
  parameter int IN_WORDS  = DEF_IN_WORDS,
  parameter int OUT_WORDS = DEF_OUT_WORDS,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    srst,
  wide_to_narrow_gearbox_if.slave bus
);

  localparam int CW         = calc_cw(IN_WORDS);
  localparam int SHIFT_BITS = OUT_WORDS * WORD_LEN;

  if (!ratio_ok(IN_WORDS, OUT_WORDS)) begin : g_bad_ratio
    $error("wide_to_narrow_gearbox: IN_WORDS must be a multiple of OUT_WORDS");
  end

  typedef logic [WORD_LEN-1:0] word_t;

  word_t [IN_WORDS-1:0] store_q;
  word_t [IN_WORDS-1:0] store_d;
  word_t [IN_WORDS-1:0] din_masked;

  logic [CW-1:0] w_eff;
  logic          load;
  logic          advance;

  wide_to_narrow_gearbox_chunk_ctrl #(
    .IN_WORDS  (IN_WORDS),
    .OUT_WORDS (OUT_WORDS)
  ) u_chunk_ctrl (
    .clk        (clk),
    .srst       (srst),
    .din_valid  (bus.din_valid),
    .din_words  (bus.din_words),
    .dout_ready (bus.dout_ready),
    .din_ready  (bus.din_ready),
    .dout_valid (bus.dout_valid),
    .dout_last  (bus.dout_last),
    .dout_words (bus.dout_words),
    .w_eff      (w_eff),
    .load       (load),
    .advance    (advance)
  );

  // Valid words sit at the low indices (LSB-first) or the high indices
  // (MSB-first); everything else is cleared so partial chunks read as zero.
  always_comb begin
    din_masked = bus.din;
    for (int i = 0; i < IN_WORDS; i++) begin
      if (MSB_FIRST ? (i < IN_WORDS - int'(w_eff)) : (i >= int'(w_eff))) begin
        din_masked[i] = '0;
      end
    end
  end

  // The emitted chunk always sits at the output end; each transfer moves the
  // next one into place and zero-fills behind it.
  always_comb begin
    store_d = store_q;
    if (load) begin
      store_d = din_masked;
    end else if (advance) begin
      store_d = MSB_FIRST ? (store_q << SHIFT_BITS) : (store_q >> SHIFT_BITS);
    end
  end

  // NOTE: the storage is a plain register bank, not a RAM, and it must be
  // cleared on reset because an idle gearbox presents all-zero dout.
  always_ff @(posedge clk) begin
    if (srst) begin
      store_q <= '0;
    end else begin
      store_q <= store_d;
    end
  end

  if (MSB_FIRST) begin : g_msb_out
    assign bus.dout = store_q[IN_WORDS-1 -: OUT_WORDS];
  end else begin : g_lsb_out
    assign bus.dout = store_q[OUT_WORDS-1:0];
  end

endmodule

// File: doc/wide_to_narrow_gearbox.md
Name: wide_to_narrow_gearbox

Overview:
- Parametrised down-converter: accepts one wide beat of IN_WORDS words and emits it as successive narrow beats of OUT_WORDS words.
- Sits between wide datapath stages (e.g. 20-lane 66b block streams) and narrower lanes.
- Over the fixed 20-to-5 converter it adds: a partial final beat via a word count, a selectable chunk order, a per-beat word count and a last-beat flag.
- Both sides use valid/ready; back-to-back operation at full output rate is supported.

Parameters:
- WORD_LEN, 66, bits per word.
- IN_WORDS, 20, words per input beat.
- OUT_WORDS, 5, words per output beat; IN_WORDS must be an integer multiple of it, checked at elaboration.
- MSB_FIRST, 0, 0 = least significant chunk emitted first; 1 = most significant chunk first.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- din  in  IN_WORDS*WORD_LEN  wide input beat.
- din_words  in  CW = clog2(IN_WORDS+1)  valid words in din; 0 is treated as IN_WORDS.
- din_valid  in  1  input beat present.
- din_ready  out  1  block accepts din this cycle.
- dout  out  OUT_WORDS*WORD_LEN  narrow output beat.
- dout_words  out  clog2(OUT_WORDS+1)  valid words in dout, 1..OUT_WORDS.
- dout_last  out  1  final chunk of the current input beat.
- dout_valid  out  1  output beat present.
- dout_ready  in  1  consumer accepts dout.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and srst.
- Reset values:
  - dout_valid=0, dout_last=0, dout_words=0, dout=0.
  - Internal storage zeroed; remaining-chunk count = 0; din_ready=1 after reset.
- Reset mid-operation discards all held chunks. The next cycle is idle with no dout_valid.
- Constants:
  - NCH = IN_WORDS/OUT_WORDS.
  - Chunk count per beat: n = ceil(w/OUT_WORDS), where w = din_words, or IN_WORDS when din_words is 0.
  - Values of din_words above IN_WORDS are clamped to IN_WORDS.
- State:
  - storage register (IN_WORDS words).
  - remaining counter 0..NCH.
  - tail count, the word count of the final chunk = w - (n-1)*OUT_WORDS.
- Handshake:
  - din_ready = (remaining==0) or (remaining==1 and dout_ready).
  - dout_valid = (remaining!=0).
  - Input accepted when din_valid & din_ready. Output transfer when dout_valid & dout_ready.
- On accept:
  - storage loads din with words at index >= w forced to zero.
  - remaining <= n; tail latched.
  - First dout is visible the cycle after accept (1-cycle latency).
- On output transfer without accept:
  - remaining decrements.
  - storage shifts by OUT_WORDS words toward the output end, zero-filling.
- Simultaneous transfer and accept (remaining==1): the load wins. The final chunk leaves and the new beat appears the next cycle with no bubble.
- Chunk order:
  - MSB_FIRST=0: dout = storage word slots [OUT_WORDS-1:0]. Valid words occupy the low indices of din.
  - MSB_FIRST=1: dout = the top OUT_WORDS slots; shift is toward the top. Valid words occupy the high indices of din, and the partial chunk is the least significant one.
- dout_last = (remaining==1).
- dout_words = tail when remaining==1, else OUT_WORDS.
- Unused words in a partial chunk read as zero.
- dout and its flags are stable while dout_valid & ~dout_ready.
- din_valid while din_ready=0 has no effect. The source must hold din.
- Only NCH counts are legal; the counter never wraps. remaining==0 with dout_ready=1 causes no decrement.

Decomposition:
- Shared package holds:
  - clog2 function.
  - NCH and CW derivations.
  - the elaboration check IN_WORDS % OUT_WORDS == 0.
- One natural sub-module: gearbox_chunk_ctrl. It owns the remaining counter, tail count, handshake and last/words flags. The top level holds the storage shifter and masking.

Test Plan:
- Defaults with WORD_LEN=8, full beat, words 0..19 = 0x00..0x13, dout_ready=1 -> 4 beats {00..04},{05..09},{0A..0E},{0F..13}; dout_words=5 each; dout_last only on the 4th; din_ready high in the 4th cycle.
- Back-to-back full beats, din_valid held, dout_ready=1 -> dout_valid continuously high; 8 output beats in 8 cycles; no bubble.
- din_words=7 -> 2 beats; the second carries words 05,06 plus three zero words, dout_words=2, dout_last=1. din_words=0 behaves as 20.
- Backpressure: dout_ready low for 3 cycles on chunk 2 -> dout stable, din_ready=0, remaining unchanged; chunks resume in order with none lost or duplicated.
- MSB_FIRST=1, full beat -> first chunk is words 0F..13. With din_words=7 -> first chunk is words 0F..13, the second carries words 0D,0E with dout_words=2.
- srst asserted mid-beat after the 2nd chunk -> next cycle dout_valid=0, din_ready=1; a new beat then emits from its chunk 0.
